// File: rtl/portout_q.sv
// Router output-port stage: filters deserialized packets by PORT_ID into a FIFO and
// re-serializes them with frame_n/valid_n. Define PORTOUT_PARITY_EN to append an even-parity bit.
module portout_q #(
   parameter logic [3:0]  PORT_ID = 4'd0,
   parameter int unsigned DEPTH   = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [3:0]  addr,
   input  logic [31:0] payload,
   input  logic        vld,
   output logic        frameo_n,
   output logic        valido_n,
   output logic        dout,
   output logic        clr,
   output logic        busy,
   output logic        full,
   output logic [7:0]  drop_cnt
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
`ifdef PORTOUT_PARITY_EN
   localparam int unsigned SW = 33;
`else
   localparam int unsigned SW = 32;
`endif
   localparam logic [5:0]    LAST    = 6'(SW - 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state_q, state_d;
   logic            vld_q, clr_q;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [7:0]      drop_q, drop_d;
   logic [SW-1:0]   pkt_q, pkt_d;
   logic [5:0]      bit_q, bit_d;
   logic [31:0]     mem_q [DEPTH];
   logic            accept, match, push, pop, drop;

   // A held vld yields one event: only the rising edge is an accept.
   assign accept = vld & ~vld_q;
   assign match  = (addr == PORT_ID);
   assign push   = accept & match & (count_q != DEPTH_C);
   assign drop   = accept & match & (count_q == DEPTH_C);

   always_comb begin
      state_d = state_q;
      pkt_d   = pkt_q;
      bit_d   = bit_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               bit_d   = '0;
               state_d = SEND;
`ifdef PORTOUT_PARITY_EN
               pkt_d   = {^mem_q[rd_ptr_q], mem_q[rd_ptr_q]};
`else
               pkt_d   = mem_q[rd_ptr_q];
`endif
            end
         end
         SEND: begin
            if (bit_q == LAST) begin
               state_d = IDLE;
            end else begin
               bit_d = bit_q + 6'd1;
               pkt_d = pkt_q >> 1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      drop_d   = drop_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= payload;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         vld_q    <= 1'b0;
         clr_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         drop_q   <= '0;
         pkt_q    <= '0;
         bit_q    <= '0;
      end else begin
         state_q  <= state_d;
         vld_q    <= vld;
         clr_q    <= accept;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
         pkt_q    <= pkt_d;
         bit_q    <= bit_d;
      end
   end

   // The final bit of a packet carries frameo_n=1 as the end marker.
   assign busy     = (state_q == SEND);
   assign valido_n = ~busy;
   assign frameo_n = ~busy | (bit_q == LAST);
   assign dout     = busy & pkt_q[0];
   assign full     = (count_q == DEPTH_C);
   assign clr      = clr_q;
   assign drop_cnt = drop_q;

endmodule
